// File: rtl/jk_updown_counter.sv
// WIDTH-bit synchronous up/down counter cell built from per-bit JK toggle terms,
// with parallel load, optional reload at terminal count and a combinational carry/borrow.
module jk_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CK,
    input  logic             nCL,
    input  logic             EN,
    input  logic             UP,
    input  logic             nLD,
    input  logic [WIDTH-1:0] D,
    input  logic             RELOAD,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             CO,
    output logic             TC
);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;

    logic [WIDTH-1:0] w_up_run;
    logic [WIDTH-1:0] w_dn_run;
    logic [WIDTH-1:0] w_toggle;
    logic             w_terminal;
    logic             w_wrap;

    // w_up_run[i] is high when every bit below i is 1; w_dn_run[i] when every bit below i is 0.
    // Built in one process so the ripple chain is an ordinary combinational cascade.
    always_comb begin
        w_up_run    = '0;
        w_dn_run    = '0;
        w_up_run[0] = 1'b1;
        w_dn_run[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_up_run[i] = w_up_run[i-1] & r_q[i-1];
            w_dn_run[i] = w_dn_run[i-1] & ~r_q[i-1];
        end
    end

    assign w_toggle   = EN ? (UP ? w_up_run : w_dn_run) : '0;
    assign w_terminal = UP ? (w_up_run[WIDTH-1] & r_q[WIDTH-1])
                           : (w_dn_run[WIDTH-1] & ~r_q[WIDTH-1]);
    assign w_wrap     = EN & w_terminal;

    // At terminal count every toggle term is set, so r_q ^ w_toggle is exactly the wrap value.
    // NOTE: state registers use non-blocking assignments so all bits update from the same old r_q.
    always_ff @(posedge CK or negedge nCL) begin
        if (!nCL) begin
            r_q  <= '0;
            r_tc <= 1'b0;
        end else if (!nLD) begin
            r_q  <= D;
            r_tc <= 1'b0;
        end else if (w_wrap) begin
            r_q  <= RELOAD ? D : (r_q ^ w_toggle);
            r_tc <= 1'b1;
        end else begin
            r_q  <= r_q ^ w_toggle;
            r_tc <= 1'b0;
        end
    end

    assign Q  = r_q;
    assign nQ = ~r_q;
    assign CO = w_wrap;
    assign TC = r_tc;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed bench for jk_updown_counter: reset, wrap, divider, priority,
// direction flip and a two-stage cascade, with hand-computed expectations.
module tb_jk_updown_counter;

    logic       ck;
    logic       ncl;
    logic       en, up, nld, reload;
    logic [3:0] d;
    logic [3:0] q, nq;
    logic       co, tc;

    logic       c_up, c_nld;
    logic [3:0] c_d_lo, c_d_hi;
    logic [3:0] c_q_lo, c_nq_lo, c_q_hi, c_nq_hi;
    logic       c_co_lo, c_co_hi, c_tc_lo, c_tc_hi;

    int total = 0;
    int bad   = 0;

    jk_updown_counter #(.WIDTH(4)) u_dut (
        .CK(ck), .nCL(ncl), .EN(en), .UP(up), .nLD(nld), .D(d), .RELOAD(reload),
        .Q(q), .nQ(nq), .CO(co), .TC(tc)
    );

    jk_updown_counter #(.WIDTH(4)) u_lo (
        .CK(ck), .nCL(ncl), .EN(1'b1), .UP(c_up), .nLD(c_nld), .D(c_d_lo), .RELOAD(1'b0),
        .Q(c_q_lo), .nQ(c_nq_lo), .CO(c_co_lo), .TC(c_tc_lo)
    );

    jk_updown_counter #(.WIDTH(4)) u_hi (
        .CK(ck), .nCL(ncl), .EN(c_co_lo), .UP(c_up), .nLD(c_nld), .D(c_d_hi), .RELOAD(1'b0),
        .Q(c_q_hi), .nQ(c_nq_hi), .CO(c_co_hi), .TC(c_tc_hi)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    logic [3:0] div_q  [6] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd4, 4'd3};
    logic       div_tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        ncl = 1'b0; en = 1'b1; up = 1'b1; nld = 1'b1; reload = 1'b0; d = 4'h0;
        c_up = 1'b1; c_nld = 1'b1; c_d_lo = 4'h0; c_d_hi = 4'h0;

        // Reset held with clock running
        tick(); tick();
        check("rst_q", 16'(q), 16'h0);
        check("rst_nq", 16'(nq), 16'hF);
        check("rst_tc", 16'(tc), 16'h0);
        check("rst_co_up", 16'(co), 16'h0);
        up = 1'b0; #1;
        check("rst_co_down", 16'(co), 16'h1);
        up = 1'b1;
        ncl = 1'b1;
        tick(); tick(); tick();
        check("release_q3", 16'(q), 16'h3);
        check("release_tc", 16'(tc), 16'h0);

        // Up wrap
        nld = 1'b0; d = 4'hE;
        tick();
        check("load_e", 16'(q), 16'hE);
        nld = 1'b1; #1;
        check("co_at_e", 16'(co), 16'h0);
        tick();
        check("up_f", 16'(q), 16'hF);
        check("co_at_f", 16'(co), 16'h1);
        check("tc_at_f", 16'(tc), 16'h0);
        tick();
        check("wrap_0", 16'(q), 16'h0);
        check("wrap_tc", 16'(tc), 16'h1);
        check("wrap_nq", 16'(nq), 16'hF);
        tick();
        check("after_wrap_1", 16'(q), 16'h1);
        check("after_wrap_tc", 16'(tc), 16'h0);

        // Down wrap without reload
        up = 1'b0; nld = 1'b0; d = 4'h0;
        tick();
        nld = 1'b1;
        tick();
        check("down_wrap_q", 16'(q), 16'hF);
        check("down_wrap_tc", 16'(tc), 16'h1);

        // Divide-by-5 divider
        reload = 1'b1; d = 4'd4; nld = 1'b0;
        tick();
        check("div_preload", 16'(q), 16'h4);
        nld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("div_q%0d", i), 16'(q), 16'(div_q[i]));
            check($sformatf("div_tc%0d", i), 16'(tc), 16'(div_tc[i]));
        end
        tick(); tick(); tick();
        check("div_at_0", 16'(q), 16'h0);
        en = 1'b0; #1;
        check("co_gated", 16'(co), 16'h0);
        tick(); tick(); tick();
        check("frozen_q", 16'(q), 16'h0);
        check("frozen_tc", 16'(tc), 16'h0);
        en = 1'b1; #1;
        check("co_enabled", 16'(co), 16'h1);
        tick();
        check("reload_q", 16'(q), 16'h4);
        check("reload_tc", 16'(tc), 16'h1);

        // Load beats reload at terminal
        tick(); tick(); tick(); tick();
        check("prio_at_0", 16'(q), 16'h0);
        nld = 1'b0; d = 4'h5;
        tick();
        check("prio_q", 16'(q), 16'h5);
        check("prio_tc", 16'(tc), 16'h0);
        nld = 1'b1;

        // Asynchronous clear between edges
        #2 ncl = 1'b0;
        #1;
        check("async_q", 16'(q), 16'h0);
        check("async_nq", 16'(nq), 16'hF);
        ncl = 1'b1;

        // Direction flip at terminal
        reload = 1'b0; up = 1'b0; #1;
        check("flip_co_down", 16'(co), 16'h1);
        up = 1'b1; #1;
        check("flip_co_up", 16'(co), 16'h0);
        tick();
        check("flip_q", 16'(q), 16'h1);
        check("flip_tc", 16'(tc), 16'h0);

        // Two-stage cascade
        c_nld = 1'b0; c_d_lo = 4'hF; c_d_hi = 4'h0;
        tick();
        check("casc_load", {8'h0, c_q_hi, c_q_lo}, 16'h000F);
        c_nld = 1'b1; c_up = 1'b1;
        tick();
        check("casc_up", {8'h0, c_q_hi, c_q_lo}, 16'h0010);
        c_up = 1'b0;
        tick();
        check("casc_down", {8'h0, c_q_hi, c_q_lo}, 16'h000F);
        check("casc_nq", {8'h0, c_nq_hi, c_nq_lo}, 16'h00F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
